// File: rtl/reset_seq_pkg.sv
// Shared state encoding and parameter defaults for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_HOLD_CYCLES    = 8;
  localparam int DEF_STAGGER_CYCLES = 2;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_CNT_W          = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-release synchroniser: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic rst_s
);

  logic [STAGES-1:0] sync_r;

  // Shift ones in once the asynchronous reset is released.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], 1'b1};
    end
  end

  assign rst_s = sync_r[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged per-channel reset release after power-on or a software re-reset request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int TMR_MAX = max_int(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAG_LOAD = TMR_W'(STAGGER_CYCLES - 1);

  logic              rst_s;
  seq_state_t        state_r, state_s;
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic [NUM_CH-1:0] sel_r, sel_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [NUM_CH-1:0] ch_r, ch_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [CNT_W-1:0]  cyc_r, cyc_s;
  int                lo_s;
  logic [IDX_W:0]    hit_s;
  logic [IDX_W:0]    nxt_s;
  logic              more_s;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk    (clk),
    .arst_n (rst),
    .rst_s  (rst_s)
  );

  // Lowest selected channel strictly above index lo; MSB flags a hit.
  function automatic logic [IDX_W:0] find_above(input logic [NUM_CH-1:0] s, input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (s[k] && (k > lo)) begin
        r = {1'b1, IDX_W'(k)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Channel search: first release scans from the bottom, later ones from the last released.
  always_comb begin
    if (state_r == ST_RELEASE) begin
      lo_s = int'(idx_r);
    end else begin
      lo_s = -1;
    end
    hit_s  = find_above(sel_r, lo_s);
    nxt_s  = find_above(sel_r, int'(hit_s[IDX_W-1:0]));
    more_s = nxt_s[IDX_W];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_s = state_r;
    tmr_s   = tmr_r;
    sel_s   = sel_r;
    idx_s   = idx_r;
    ch_s    = ch_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    cyc_s   = cyc_r;
    if (!rst_s) begin
      state_s = ST_ASSERT;
      tmr_s   = '0;
      sel_s   = '1;
      idx_s   = '0;
      ch_s    = '0;
      busy_s  = 1'b1;
      cyc_s   = '0;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          state_s = ST_HOLD;
          tmr_s   = HOLD_LOAD;
          busy_s  = 1'b1;
        end
        ST_HOLD, ST_RELEASE: begin
          if ((state_r == ST_RELEASE) && done_r) begin
            state_s = ST_RUN;
            busy_s  = 1'b0;
            cyc_s   = '0;
          end else if (tmr_r != '0) begin
            tmr_s = tmr_r - TMR_W'(1);
          end else if (hit_s[IDX_W]) begin
            state_s = ST_RELEASE;
            idx_s   = hit_s[IDX_W-1:0];
            ch_s[hit_s[IDX_W-1:0]] = 1'b1;
            tmr_s   = STAG_LOAD;
            done_s  = !more_s;
          end else begin
            // Unreachable with a non-empty selection; recover to RUN.
            state_s = ST_RUN;
            busy_s  = 1'b0;
            cyc_s   = '0;
          end
        end
        ST_RUN: begin
          cyc_s = cyc_r + CNT_W'(1);
          if (sw_rst_req && (ch_mask != '0)) begin
            sel_s   = ch_mask;
            ch_s    = ch_r & ~ch_mask;
            state_s = ST_ASSERT;
            busy_s  = 1'b1;
            cyc_s   = '0;
            tmr_s   = '0;
            idx_s   = '0;
          end else begin
            sel_s = sel_r;
          end
        end
        default: begin
          state_s = ST_ASSERT;
          tmr_s   = '0;
          sel_s   = '1;
          idx_s   = '0;
          ch_s    = '0;
          busy_s  = 1'b1;
          cyc_s   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_ASSERT;
      tmr_r   <= '0;
      sel_r   <= '1;
      idx_r   <= '0;
      ch_r    <= '0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
      cyc_r   <= '0;
    end else begin
      state_r <= state_s;
      tmr_r   <= tmr_s;
      sel_r   <= sel_s;
      idx_r   <= idx_s;
      ch_r    <= ch_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cyc_r   <= cyc_s;
    end
  end

  assign ch_rst_n  = ch_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cycle_cnt = cyc_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer against a release-schedule model.
module tb_reset_sequencer;

  localparam int HOLD = 8;
  localparam int STAG = 2;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_rst_req = 1'b0;
  logic [3:0]  ch_mask = 4'b0;
  logic [3:0]  ch_rst_n, w_ch_rst_n;
  logic        busy, w_busy, done, w_done;
  logic [31:0] cycle_cnt;
  logic [3:0]  w_cycle_cnt;

  int total = 0;
  int bad = 0;

  // Model: t = edges since rst rose; a sequence starts at edge m_start.
  int         t = 0;
  int         m_start = SYNC;
  logic [3:0] m_sel = 4'hF;
  logic       m_rst = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .ch_mask(ch_mask),
    .ch_rst_n(ch_rst_n), .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  reset_sequencer #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .ch_mask(ch_mask),
    .ch_rst_n(w_ch_rst_n), .busy(w_busy), .done(w_done), .cycle_cnt(w_cycle_cnt)
  );

  // Expected {ch, busy, done, cnt32, w_ch, w_busy, w_done, cnt4}; busy is bit 43.
  function automatic logic [47:0] exp_vec();
    logic [3:0]  e_ch;
    logic        e_b, e_d;
    logic [31:0] e_cc;
    int k, rel, last;
    if (m_rst) return {4'b0, 1'b1, 1'b0, 32'd0, 4'b0, 1'b1, 1'b0, 4'd0};
    e_ch = ~m_sel;
    k = 0;
    last = m_start;
    for (int b = 0; b < 4; b++) begin
      if (m_sel[b]) begin
        rel = m_start + 1 + HOLD + k * STAG;
        if (t >= rel) e_ch[b] = 1'b1;
        last = rel;
        k++;
      end
    end
    e_b  = (t <= last);
    e_d  = (t == last);
    e_cc = (t > last) ? 32'(t - last - 1) : 32'd0;
    return {e_ch, e_b, e_d, e_cc, e_ch, e_b, e_d, e_cc[3:0]};
  endfunction

  function automatic logic [47:0] obs_vec();
    return {ch_rst_n, busy, done, cycle_cnt, w_ch_rst_n, w_busy, w_done, w_cycle_cnt};
  endfunction

  task automatic tick();
    logic [47:0] e;
    logic        acc;
    logic [3:0]  cap;
    e   = exp_vec();
    acc = !m_rst && !e[43] && sw_rst_req && (ch_mask != 4'b0);
    cap = ch_mask;
    @(posedge clk);
    #1;
    if (!m_rst) t = t + 1;
    if (acc) begin
      m_start = t;
      m_sel   = cap;
    end
  endtask

  task automatic rst_low();
    rst = 1'b0;
    m_rst = 1'b1;
    t = 0;
  endtask

  task automatic rst_high();
    rst = 1'b1;
    m_rst = 1'b0;
    t = 0;
    m_start = SYNC;
    m_sel = 4'hF;
  endtask

  task automatic test_reset();
    logic [47:0] e;
    #2;
    rst_low();
    for (int i = 0; i < 4; i++) begin
      #1;
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL reset i=%0d got=%h want=%h", i, obs_vec(), e);
      end
      sw_rst_req = 1'($urandom_range(0, 1));
      ch_mask = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic test_power_on();
    logic [47:0] e;
    rst_high();
    for (int i = 0; i < 25; i++) begin
      sw_rst_req = (t < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      ch_mask = 4'($urandom_range(0, 15));
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL power_on t=%0d got=%h want=%h", t, obs_vec(), e);
      end
      tick();
    end
  endtask

  task automatic test_sw_reset();
    logic [47:0] e;
    // Empty mask in RUN must change nothing.
    for (int i = 0; i < 3; i++) begin
      sw_rst_req = 1'b1;
      ch_mask = 4'b0000;
      tick();
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL sw_empty t=%0d got=%h want=%h", t, obs_vec(), e);
      end
    end
    sw_rst_req = 1'b1;
    ch_mask = 4'b0110;
    for (int i = 0; i < 16; i++) begin
      tick();
      sw_rst_req = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      ch_mask = 4'($urandom_range(0, 15));
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL sw_reset t=%0d got=%h want=%h", t, obs_vec(), e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [47:0] e;
    sw_rst_req = 1'b0;
    rst_low();
    tick();
    rst_high();
    for (int i = 0; i < 12; i++) tick();
    rst_low();
    #1;
    e = exp_vec();
    total++;
    if (obs_vec() !== e) begin
      bad++;
      $display("FAIL mid_reset_async got=%h want=%h", obs_vec(), e);
    end
    tick();
    tick();
    rst_high();
    for (int i = 0; i < 22; i++) begin
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL mid_reset_restart t=%0d got=%h want=%h", t, obs_vec(), e);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [47:0] e;
    for (int i = 0; i < 600; i++) begin
      if (m_rst) rst_high();
      else if ($urandom_range(0, 199) == 0) rst_low();
      sw_rst_req = ($urandom_range(0, 7) == 0);
      ch_mask = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      #1;
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL random i=%0d t=%0d got=%h want=%h", i, t, obs_vec(), e);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [47:0] e;
    logic [3:0]  prev;
    logic        saw_wrap;
    saw_wrap = 1'b0;
    if (m_rst) rst_high();
    sw_rst_req = 1'b0;
    prev = w_cycle_cnt;
    for (int i = 0; i < 60; i++) begin
      tick();
      e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL wrap t=%0d got=%h want=%h", t, obs_vec(), e);
      end
      if (prev == 4'd15 && w_cycle_cnt == 4'd0 && !w_busy && w_ch_rst_n == 4'hF) saw_wrap = 1'b1;
      prev = w_cycle_cnt;
    end
    total++;
    if (saw_wrap !== 1'b1) begin
      bad++;
      $display("FAIL wrap_seen got=%b want=1", saw_wrap);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independently released reset channels, 1..16.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles all selected channels stay asserted after synchronised reset release, >=1.
REQ-003 Parameter STAGGER_CYCLES, default 2: cycles between successive channel releases, >=1.
REQ-004 Parameter SYNC_STAGES, default 2: depth of the reset-release synchroniser, >=2.
REQ-005 Parameter CNT_W, default 32: width of the run-time cycle counter.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Port sw_rst_req, input, 1: software re-reset request, sampled on clk.
REQ-009 Port ch_mask, input, NUM_CH: bit k=1 selects channel k for a software re-reset.
REQ-010 Port ch_rst_n, output, NUM_CH: active-low per-channel resets to downstream blocks.
REQ-011 Port busy, output, 1: high while any sequence is in progress.
REQ-012 Port done, output, 1: one-cycle pulse in the cycle the last selected channel is released.
REQ-013 Port cycle_cnt, output, CNT_W: cycles elapsed in RUN since the last sequence completed.

Function
REQ-014 The FSM SHALL have states ASSERT, HOLD, RELEASE and RUN.
REQ-015 rst_s, the synchronised reset, SHALL go low asynchronously with rst and SHALL go high SYNC_STAGES rising edges after rst goes high.
REQ-016 While rst_s=0, the block SHALL hold state ASSERT with the select register set to all ones.
REQ-017 ASSERT SHALL last exactly one cycle with rst_s=1, then move to HOLD.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles, then move to RELEASE.
REQ-019 RELEASE SHALL drive selected channels' ch_rst_n high in ascending index order.
- First selected channel released in the first RELEASE cycle.
- Each later selected channel released STAGGER_CYCLES cycles after the previous one.
- Unselected channels are skipped and consume no cycles.
REQ-020 done SHALL be 1 in the cycle the last selected channel is released; the next cycle the state SHALL be RUN.
REQ-021 In RUN: busy=0 and cycle_cnt=0 in the first RUN cycle, +1 each cycle after, wrapping from 2^CNT_W-1 to 0.
REQ-022 If sw_rst_req=1 at an edge in RUN with ch_mask non-zero:
- The select register SHALL capture ch_mask.
- Selected channels' ch_rst_n SHALL go 0 after that edge.
- State SHALL become ASSERT, busy=1 and cycle_cnt=0.
- Unselected channels SHALL remain 1 throughout.
- No synchroniser delay applies.
REQ-023 sw_rst_req SHALL be ignored when ch_mask=0 or when busy=1.
REQ-024 Once a sequence has started, changes on ch_mask SHALL have no effect on it.
REQ-025 rst low at any time, mid-sequence included, SHALL override all activity per REQ-026.

Reset
REQ-026 When rst is low, the following SHALL hold asynchronously:
- ch_rst_n=all zeros
- busy=1
- done=0
- cycle_cnt=0
- state=ASSERT
- all counters=0
- synchroniser flops=0
- select register=all ones

Structure
REQ-027 Package reset_seq_pkg SHALL hold the state encoding and the parameter defaults.
REQ-028 The synchroniser SHALL be a sub-module named rst_sync, parameterised by SYNC_STAGES, with asynchronous assert and synchronous deassert.
REQ-029 Hold and stagger timing SHALL share one down-counter sized to the larger of HOLD_CYCLES and STAGGER_CYCLES.

Verification
All scenarios use default parameters; edges are numbered from the first rising clk edge after rst rises.
REQ-030 Power-on: rst low for 3 cycles, then high. Required response:
- ch_rst_n=0000 through edge 10.
- Bit 0 high after edge 11, bit 1 after edge 13, bit 2 after edge 15.
- Bit 3 high with done=1 after edge 17.
- busy=0 and cycle_cnt=0 after edge 18; cycle_cnt=1 after edge 19.
REQ-031 Software reset: in RUN, sw_rst_req=1 with ch_mask=0110 at edge N. Required response:
- ch_rst_n=1001 after edge N.
- Bit 1 released after edge N+9.
- Bit 2 released after edge N+11, with done=1.
- Bits 0 and 3 stay 1 throughout.
REQ-032 Ignored requests:
- sw_rst_req=1 during power-on HOLD -> no timing change versus REQ-030.
- sw_rst_req=1 with ch_mask=0000 in RUN -> no change on any output.
REQ-033 Mid-sequence reset: rst low after edge 12 -> ch_rst_n=0000 and busy=1 immediately; the REQ-030 sequence restarts after rst rises.
REQ-034 Wrap: CNT_W=4, run 16 RUN cycles -> cycle_cnt goes 15 then 0, with no effect on busy or ch_rst_n.
